// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-port round-robin arbiter for a single-port synchronous-read data memory
// with a bounded ownership lock for uninterrupted multi-word sequences.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    state_t     state;
    state_t     state_n;
    logic       last;
    logic       last_n;
    logic [7:0] lock_cnt;
    logic [7:0] lock_cnt_n;
    logic [7:0] cnt_inc;
    logic       gnt0;
    logic       gnt1;
    logic       rvalid0_q;
    logic       rvalid1_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ARB;
            last      <= 1'b1;
            lock_cnt  <= 8'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            lock_cnt  <= lock_cnt_n;
            rvalid0_q <= gnt0 & ~r0_we;
            rvalid1_q <= gnt1 & ~r1_we;
        end
    end

    always_comb begin
        state_n    = state;
        last_n     = last;
        lock_cnt_n = lock_cnt;
        cnt_inc    = lock_cnt + 8'd1;
        case (state)
            ARB: begin
                if (gnt0) begin
                    last_n = 1'b0;
                    if (r0_lock) begin
                        state_n    = LOCK0;
                        lock_cnt_n = 8'd1;
                    end
                end else if (gnt1) begin
                    last_n = 1'b1;
                    if (r1_lock) begin
                        state_n    = LOCK1;
                        lock_cnt_n = 8'd1;
                    end
                end
            end
            // The counter advances even while the owner idles, so a silent owner still times out.
            LOCK0: begin
                lock_cnt_n = cnt_inc;
                if ((gnt0 && !r0_lock) || cnt_inc >= LOCK_LIMIT) begin
                    state_n    = ARB;
                    lock_cnt_n = 8'd0;
                    last_n     = 1'b0;
                end
            end
            LOCK1: begin
                lock_cnt_n = cnt_inc;
                if ((gnt1 && !r1_lock) || cnt_inc >= LOCK_LIMIT) begin
                    state_n    = ARB;
                    lock_cnt_n = 8'd0;
                    last_n     = 1'b1;
                end
            end
            default: state_n = ARB;
        endcase
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            case (state)
                ARB: begin
                    gnt0 = r0_req & (~r1_req | last);
                    gnt1 = r1_req & ~gnt0;
                end
                LOCK0:   gnt0 = r0_req;
                LOCK1:   gnt1 = r1_req;
                default: ;
            endcase
        end
    end

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign mem_en    = gnt0 | gnt1;
    assign mem_we    = (gnt0 & r0_we) | (gnt1 & r1_we);
    assign mem_addr  = gnt1 ? r1_addr : r0_addr;
    assign mem_wdata = gnt1 ? r1_wdata : r0_wdata;

    // Gating with reset drops a response whose read was granted just before reset asserted.
    assign r0_rvalid = rvalid0_q & reset;
    assign r1_rvalid = rvalid1_q & reset;
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

endmodule
